signal_select_mux: RTL and testbench
====================================

# signal_select_mux

Parametrised, registered channel selector for the DAC/display path. It picks one of NUM_CH sample streams (DDS waveforms, modulator outputs, LFSR) in step with the sample strobe. On every channel change it mutes the output to midscale for a programmable number of samples, so switching never glitches the DAC. An optional auto-scan mode rotates through the channels on a fixed sample period. It sits between the waveform/modulator generators and the DAC/scope output stage.

## Interface
- NUM_CH, 8, number of input channels (2..16)
- WIDTH, 12, sample width in bits
- MUTE_SAMPLES, 4, sample strobes output at midscale per switch (0 = no mute)
- SCAN_SAMPLES, 1024, sample strobes per channel in auto-scan (≥1)
- SEL_W (localparam), $clog2(NUM_CH), select width
- clk  in  1  system clock
- reset  in  1  reset, asynchronous and active-high
- sample_en  in  1  one-cycle sample strobe from the DDS timebase
- ch_data  in  NUM_CH*WIDTH  packed samples; channel k at [k*WIDTH +: WIDTH]
- sel  in  SEL_W  requested channel (switches, asynchronous)
- auto_scan  in  1  1 = rotate channels automatically (switch, asynchronous)
- out_data  out  WIDTH  selected sample, registered
- out_valid  out  1  pulses for one cycle, one cycle after sample_en
- active_ch  out  SEL_W  channel currently routed
- muted  out  1  high while in MUTE state

## Operation
- sel and auto_scan each pass through a 2-flop synchroniser (sel_s, scan_s).
- Requested channel req = scan_s ? scan_ch : sel_s. In manual mode, sel_s ≥ NUM_CH is invalid: req = active_ch, so the request is ignored.
- All state below advances only on cycles with sample_en = 1. Otherwise everything holds.
- States:
  - RUN: if req == active_ch, out_data ← ch_data[active_ch].
  - RUN, switch: if req ≠ active_ch, then active_ch ← req. If MUTE_SAMPLES = 0, out_data ← ch_data[req] and the state stays RUN. Otherwise out_data ← MID, mute_cnt ← MUTE_SAMPLES−1, and the state goes to MUTE.
  - MUTE: out_data ← MID.
  - MUTE, new request: if req ≠ active_ch, then active_ch ← req and mute_cnt ← MUTE_SAMPLES−1 (mute restarts).
  - MUTE, expiry: else if mute_cnt = 0, go to RUN; else mute_cnt decrements.
  - Net effect: exactly MUTE_SAMPLES midscale samples follow the last switch.
- MID = 1 << (WIDTH−1), i.e. midscale offset binary (2048 for 12 bits).
- Auto-scan:
  - On the rising edge of scan_s: scan_ch ← active_ch and scan_cnt ← 0, so entering scan mode causes no jump.
  - While scan_s = 1, each strobe increments scan_cnt. When scan_cnt = SCAN_SAMPLES−1, scan_cnt ← 0 and scan_ch ← scan_ch+1, wrapping NUM_CH−1 → 0.
  - When scan_s = 0, scan_cnt ← 0 and scan_ch holds.
- muted = (state == MUTE).
- Reset values: out_data = MID, out_valid = 0, active_ch = 0, muted = 0, state = RUN, synchronisers/scan_ch/scan_cnt/mute_cnt = 0.

## Timing
- out_data, active_ch and muted update on the clock edge where sample_en = 1. The strobe cycle itself uses that cycle's ch_data and req.
- out_valid = sample_en delayed by 1 cycle. It marks the cycle in which the new out_data is first stable.
- A sel change reaches req after 2 clk, then takes effect at the next sample_en.
- A scan advance is registered on strobe n and acts as a switch on strobe n+1.
- sample_en may be high on consecutive cycles; each high cycle counts as one sample.
- Asserting reset mid-MUTE forces the outputs to their reset values immediately (asynchronous). After release, the block starts in RUN on channel 0.

## Test plan
- Reset with sel = 0 and ch_data[0] = 0x123, strobe every 4 clk → out_data = 0x800 before the first strobe, then 0x123; out_valid is 1 cycle wide, 1 cycle after each strobe.
- MUTE_SAMPLES = 4, sel 0→3 with ch3 = 0xABC → after sync, 4 strobes give 0x800 with muted = 1 and active_ch = 3; the 5th strobe gives 0xABC with muted = 0.
- Switch during mute: sel 0→2, then →5 on the 2nd muted strobe → mute restarts; 4 more 0x800 samples, then ch5 data. MUTE_SAMPLES = 0 → ch data appears on the switching strobe with no mute.
- NUM_CH = 6, sel = 7 → active_ch unchanged, no mute entered, out_data tracks the old channel.
- Auto-scan with SCAN_SAMPLES = 4 and NUM_CH = 8, starting on ch6 → active_ch goes 6→7→0 with a mute after each advance. Deasserting auto_scan returns to sel.
- Reset asserted on the 2nd muted strobe → out_data = 0x800, muted = 0 and active_ch = 0 within the same cycle; normal operation resumes after release.

Source files
------------

// File: rtl/signal_select_mux.sv
// Registered channel selector for the DAC path: picks one of NUM_CH sample streams on the
// sample strobe, mutes to midscale for MUTE_SAMPLES strobes after every switch, optional auto-scan.
//
// state | meaning
// RUN   | routing ch_data[active_ch] to out_data on every strobe
// MUTE  | holding out_data at midscale after a channel switch
module signal_select_mux #(
    parameter int NUM_CH       = 8,
    parameter int WIDTH        = 12,
    parameter int MUTE_SAMPLES = 4,
    parameter int SCAN_SAMPLES = 1024,
    localparam int SEL_W       = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sample_en,
    input  logic [NUM_CH*WIDTH-1:0] ch_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    auto_scan,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic [SEL_W-1:0]        active_ch,
    output logic                    muted
);

    localparam int MC_W = (MUTE_SAMPLES > 1) ? $clog2(MUTE_SAMPLES) : 1;
    localparam int SC_W = (SCAN_SAMPLES > 1) ? $clog2(SCAN_SAMPLES) : 1;
    localparam logic [MC_W-1:0]  MUTE_LOAD = (MUTE_SAMPLES > 0) ? MC_W'(MUTE_SAMPLES - 1) : '0;
    localparam logic [SC_W-1:0]  SCAN_LAST = SC_W'(SCAN_SAMPLES - 1);
    localparam logic [SEL_W:0]   NCH       = (SEL_W + 1)'(NUM_CH);
    localparam logic [SEL_W-1:0] LAST_CH   = SEL_W'(NUM_CH - 1);
    localparam logic [WIDTH-1:0] MID       = {1'b1, {(WIDTH - 1){1'b0}}};

    typedef enum logic {RUN, MUTE} state_t;

    state_t           state;
    logic [SEL_W-1:0] sel_m, sel_s;
    logic             scan_m, scan_s, scan_q;
    logic [SEL_W-1:0] scan_ch;
    logic [SC_W-1:0]  scan_cnt;
    logic [MC_W-1:0]  mute_cnt;
    logic [SEL_W-1:0] req;
    logic             scan_rise;
    logic [WIDTH-1:0] ch_arr [2**SEL_W];

    for (genvar k = 0; k < 2**SEL_W; k++) begin : g_ch
        if (k < NUM_CH) begin : g_used
            assign ch_arr[k] = ch_data[k*WIDTH +: WIDTH];
        end else begin : g_unused
            assign ch_arr[k] = '0;
        end
    end

    // On the strobe that enters scan mode, scan_ch is stale; use active_ch so nothing jumps.
    always_comb begin
        scan_rise = scan_s && !scan_q;
        if (scan_s)
            req = scan_rise ? active_ch : scan_ch;
        else if ({1'b0, sel_s} < NCH)
            req = sel_s;
        else
            req = active_ch;
    end

    assign muted = (state == MUTE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_m     <= '0;
            sel_s     <= '0;
            scan_m    <= 1'b0;
            scan_s    <= 1'b0;
            scan_q    <= 1'b0;
            scan_ch   <= '0;
            scan_cnt  <= '0;
            mute_cnt  <= '0;
            state     <= RUN;
            active_ch <= '0;
            out_data  <= MID;
            out_valid <= 1'b0;
        end else begin
            sel_m     <= sel;
            sel_s     <= sel_m;
            scan_m    <= auto_scan;
            scan_s    <= scan_m;
            out_valid <= sample_en;
            if (sample_en) begin
                scan_q <= scan_s;
                if (scan_rise) begin
                    scan_ch  <= active_ch;
                    scan_cnt <= '0;
                end else if (scan_s) begin
                    if (scan_cnt == SCAN_LAST) begin
                        scan_cnt <= '0;
                        scan_ch  <= (scan_ch == LAST_CH) ? '0 : scan_ch + 1'b1;
                    end else begin
                        scan_cnt <= scan_cnt + 1'b1;
                    end
                end else begin
                    scan_cnt <= '0;
                end

                case (state)
                    RUN: begin
                        if (req != active_ch) begin
                            active_ch <= req;
                            if (MUTE_SAMPLES == 0) begin
                                out_data <= ch_arr[req];
                            end else begin
                                out_data <= MID;
                                mute_cnt <= MUTE_LOAD;
                                state    <= MUTE;
                            end
                        end else begin
                            out_data <= ch_arr[active_ch];
                        end
                    end
                    MUTE: begin
                        // The expiry strobe already carries live data, giving exactly
                        // MUTE_SAMPLES midscale samples after the last switch.
                        if (req != active_ch) begin
                            active_ch <= req;
                            mute_cnt  <= MUTE_LOAD;
                            out_data  <= MID;
                        end else if (mute_cnt == '0) begin
                            state    <= RUN;
                            out_data <= ch_arr[active_ch];
                        end else begin
                            mute_cnt <= mute_cnt - 1'b1;
                            out_data <= MID;
                        end
                    end
                    default: state <= RUN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_signal_select_mux.sv
// Scoreboard bench for signal_select_mux: three instances (default mute, no mute, 6 channels)
// share stimulus; a negedge monitor pops expected samples whenever a checked instance presents out_valid.
module tb_signal_select_mux;

    typedef struct packed {
        logic [11:0] d;
        logic [2:0]  a;
        logic        m;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_en;
    logic [95:0] ch_data;
    logic [2:0]  sel;
    logic        auto_scan;

    logic [11:0] od [3];
    logic        ov [3];
    logic [2:0]  ac [3];
    logic        mu [3];
    logic        en [3];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    signal_select_mux #(.NUM_CH(8), .WIDTH(12), .MUTE_SAMPLES(4), .SCAN_SAMPLES(4)) u_main (
        .clk(clk), .reset(reset), .sample_en(sample_en), .ch_data(ch_data), .sel(sel),
        .auto_scan(auto_scan), .out_data(od[0]), .out_valid(ov[0]), .active_ch(ac[0]), .muted(mu[0]));

    signal_select_mux #(.NUM_CH(8), .WIDTH(12), .MUTE_SAMPLES(0), .SCAN_SAMPLES(4)) u_nomute (
        .clk(clk), .reset(reset), .sample_en(sample_en), .ch_data(ch_data), .sel(sel),
        .auto_scan(auto_scan), .out_data(od[1]), .out_valid(ov[1]), .active_ch(ac[1]), .muted(mu[1]));

    signal_select_mux #(.NUM_CH(6), .WIDTH(12), .MUTE_SAMPLES(4), .SCAN_SAMPLES(4)) u_six (
        .clk(clk), .reset(reset), .sample_en(sample_en), .ch_data(ch_data[71:0]), .sel(sel),
        .auto_scan(auto_scan), .out_data(od[2]), .out_valid(ov[2]), .active_ch(ac[2]), .muted(mu[2]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic mon_pop(input int idx);
        exp_t e;
        int   sz;
        case (idx)
            0: sz = q0.size();
            1: sz = q1.size();
            default: sz = q2.size();
        endcase
        if (sz == 0) begin
            checks++;
            failures++;
            $display("FAIL dut%0d_unexpected_valid actual=1 required=0 at %0t", idx, $time);
        end else begin
            case (idx)
                0: e = q0.pop_front();
                1: e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            chk($sformatf("dut%0d_data", idx),   32'(od[idx]), 32'(e.d));
            chk($sformatf("dut%0d_active", idx), 32'(ac[idx]), 32'(e.a));
            chk($sformatf("dut%0d_muted", idx),  32'(mu[idx]), 32'(e.m));
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++)
            if (ov[i] && en[i]) mon_pop(i);
    end

    task automatic set_ch(input int k, input logic [11:0] v);
        ch_data[k*12 +: 12] = v;
    endtask

    task automatic set_sel(input logic [2:0] v);
        sel = v;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic set_scan(input logic v);
        auto_scan = v;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // One strobe followed by three idle cycles; idx < 0 leaves the scoreboards untouched.
    task automatic strobe(input int idx, input logic [11:0] d, input logic [2:0] a, input logic m);
        exp_t e;
        e = '{d: d, a: a, m: m};
        case (idx)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            default: ;
        endcase
        sample_en = 1'b1;
        @(posedge clk);
        #1 sample_en = 1'b0;
        @(posedge clk);
        #1;
        if (idx == 0) chk("valid_width", 32'(ov[0]), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic strobes(input int n, input int idx, input logic [11:0] d,
                           input logic [2:0] a, input logic m);
        for (int i = 0; i < n; i++) strobe(idx, d, a, m);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; sample_en = 1'b0; sel = 3'd0; auto_scan = 1'b0;
        en[0] = 1'b1; en[1] = 1'b0; en[2] = 1'b0;
        set_ch(0, 12'h123); set_ch(1, 12'h111); set_ch(2, 12'h222); set_ch(3, 12'hABC);
        set_ch(4, 12'h444); set_ch(5, 12'h555); set_ch(6, 12'h666); set_ch(7, 12'h777);
        #12;
        chk("rst_data",   32'(od[0]), 32'h800);
        chk("rst_valid",  32'(ov[0]), 32'd0);
        chk("rst_active", 32'(ac[0]), 32'd0);
        chk("rst_muted",  32'(mu[0]), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("pre_strobe_data", 32'(od[0]), 32'h800);

        // Basic routing, then a plain switch 0 -> 3
        strobes(2, 0, 12'h123, 3'd0, 1'b0);
        set_sel(3'd3);
        strobes(4, 0, 12'h800, 3'd3, 1'b1);
        strobes(2, 0, 12'hABC, 3'd3, 1'b0);

        // Switch during mute restarts the mute
        set_sel(3'd0);
        strobes(4, 0, 12'h800, 3'd0, 1'b1);
        strobe(0, 12'h123, 3'd0, 1'b0);
        set_sel(3'd2);
        strobe(0, 12'h800, 3'd2, 1'b1);
        set_sel(3'd5);
        strobes(4, 0, 12'h800, 3'd5, 1'b1);
        strobe(0, 12'h555, 3'd5, 1'b0);

        // Six-channel instance: out-of-range selects are ignored
        en[0] = 1'b0; en[2] = 1'b1;
        set_sel(3'd7);
        strobes(2, 2, 12'h555, 3'd5, 1'b0);
        set_sel(3'd6);
        strobe(2, 12'h555, 3'd5, 1'b0);
        set_ch(5, 12'h5A5);
        strobe(2, 12'h5A5, 3'd5, 1'b0);
        set_ch(5, 12'h555);
        set_sel(3'd4);
        strobes(4, 2, 12'h800, 3'd4, 1'b1);
        strobe(2, 12'h444, 3'd4, 1'b0);

        // No-mute instance: data appears on the switching strobe
        en[2] = 1'b0; en[1] = 1'b1;
        set_sel(3'd1);
        strobes(2, 1, 12'h111, 3'd1, 1'b0);
        set_sel(3'd2);
        strobe(1, 12'h222, 3'd2, 1'b0);

        // Auto-scan from channel 6 on the main instance
        en[1] = 1'b0;
        set_sel(3'd6);
        strobes(6, -1, 12'h000, 3'd0, 1'b0);
        en[0] = 1'b1;
        strobe(0, 12'h666, 3'd6, 1'b0);
        set_scan(1'b1);
        strobes(5, 0, 12'h666, 3'd6, 1'b0);
        strobes(4, 0, 12'h800, 3'd7, 1'b1);
        strobes(2, 0, 12'h800, 3'd0, 1'b1);
        set_scan(1'b0);
        strobes(4, 0, 12'h800, 3'd6, 1'b1);
        strobe(0, 12'h666, 3'd6, 1'b0);

        // Reset asserted right on the second muted strobe
        set_sel(3'd3);
        strobe(0, 12'h800, 3'd3, 1'b1);
        sample_en = 1'b1;
        @(posedge clk);
        #1 sample_en = 1'b0;
        reset = 1'b1;
        #1;
        chk("midrst_data",   32'(od[0]), 32'h800);
        chk("midrst_muted",  32'(mu[0]), 32'd0);
        chk("midrst_active", 32'(ac[0]), 32'd0);
        chk("midrst_valid",  32'(ov[0]), 32'd0);
        sel = 3'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        strobes(2, 0, 12'h123, 3'd0, 1'b0);

        repeat (4) @(posedge clk);
        chk("q0_empty", 32'(q0.size()), 32'd0);
        chk("q1_empty", 32'(q1.size()), 32'd0);
        chk("q2_empty", 32'(q2.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
